// File: rtl/hit_resolver.sv
// Two-player melee hit resolution: per-player attack phase tracking, hitbox vs. body
// overlap, one-hit-per-attack pulses, trades and hitstun counters.
module hit_resolver #(
    parameter int COORD_W        = 10,
    parameter int CHAR_WIDTH     = 64,
    parameter int CHAR_HEIGHT    = 240,
    parameter int HITBOX_WIDTH   = 20,
    parameter int HITBOX_HEIGHT  = 60,
    parameter int STARTUP_FRAMES = 3,
    parameter int ACTIVE_FRAMES  = 2,
    parameter int HITSTUN_FRAMES = 12
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               frame_tick,
    input  logic [COORD_W-1:0] char1_x,
    input  logic [COORD_W-1:0] char1_y,
    input  logic [COORD_W-1:0] char2_x,
    input  logic [COORD_W-1:0] char2_y,
    input  logic [2:0]         char1_state,
    input  logic [2:0]         char2_state,
    input  logic               char1_facing_right,
    input  logic               char2_facing_right,
    output logic               hit1_lands,
    output logic               hit2_lands,
    output logic               trade,
    output logic               p1_stunned,
    output logic               p2_stunned,
    output logic [1:0]         p1_phase_dbg,
    output logic [1:0]         p2_phase_dbg
);

    typedef enum logic [1:0] {
        PH_IDLE    = 2'd0,
        PH_STARTUP = 2'd1,
        PH_ACTIVE  = 2'd2,
        PH_SPENT   = 2'd3
    } phase_t;

    // Two bits of headroom: x + CHAR_WIDTH + HITBOX_WIDTH must never wrap.
    localparam int XW = COORD_W + 2;
    localparam int CW = 8;

    localparam logic [2:0]    ATTACK = 3'b010;
    localparam logic [XW-1:0] CHW_X  = XW'(CHAR_WIDTH);
    localparam logic [XW-1:0] CHH_X  = XW'(CHAR_HEIGHT);
    localparam logic [XW-1:0] HBW_X  = XW'(HITBOX_WIDTH);
    localparam logic [XW-1:0] HBH_X  = XW'(HITBOX_HEIGHT);
    localparam logic [XW-1:0] HBY_X  = XW'((CHAR_HEIGHT - HITBOX_HEIGHT) / 2);
    localparam logic [CW-1:0] SU_N   = CW'(STARTUP_FRAMES);
    localparam logic [CW-1:0] AC_N   = CW'(ACTIVE_FRAMES);
    localparam logic [CW-1:0] HS_N   = CW'(HITSTUN_FRAMES);

    logic [XW-1:0] pos_x [2];
    logic [XW-1:0] pos_y [2];
    logic [2:0]    st    [2];
    logic          face  [2];
    logic [XW-1:0] box_x [2];
    logic [XW-1:0] box_y [2];

    logic [1:0] overlap;
    logic [1:0] attack;
    logic [1:0] stunned;
    logic [1:0] hit_d;
    logic [1:0] hit_q;
    logic [1:0] prev_att_q;

    phase_t        phase_q [2];
    phase_t        phase_d [2];
    logic [CW-1:0] fcnt_q  [2];
    logic [CW-1:0] fcnt_d  [2];
    logic [CW-1:0] stun_q  [2];
    logic [CW-1:0] stun_d  [2];

    assign pos_x[0] = XW'(char1_x);
    assign pos_y[0] = XW'(char1_y);
    assign pos_x[1] = XW'(char2_x);
    assign pos_y[1] = XW'(char2_y);
    assign st[0]    = char1_state;
    assign st[1]    = char2_state;
    assign face[0]  = char1_facing_right;
    assign face[1]  = char2_facing_right;

    // Hitbox placement; a left-facing box near the screen edge clamps at x = 0.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            box_x[i] = '0;
            box_y[i] = '0;
            if (face[i]) begin
                box_x[i] = pos_x[i] + CHW_X;
            end else if (pos_x[i] >= HBW_X) begin
                box_x[i] = pos_x[i] - HBW_X;
            end
            box_y[i] = pos_y[i] + HBY_X;
        end
    end

    // Strict intersection of attacker i's hitbox with the other player's body.
    always_comb begin
        overlap = '0;
        for (int i = 0; i < 2; i++) begin
            overlap[i] = (box_x[i] < pos_x[1-i] + CHW_X) &&
                         (pos_x[1-i] < box_x[i] + HBW_X) &&
                         (box_y[i] < pos_y[1-i] + CHH_X) &&
                         (pos_y[1-i] < box_y[i] + HBH_X);
        end
    end

    always_comb begin
        attack  = '0;
        stunned = '0;
        hit_d   = '0;
        for (int i = 0; i < 2; i++) begin
            attack[i]  = (st[i] == ATTACK);
            stunned[i] = (stun_q[i] != '0);
            hit_d[i]   = (phase_q[i] == PH_ACTIVE) && overlap[i] && !stunned[i] && !hit_q[i];
            phase_d[i] = phase_q[i];
            fcnt_d[i]  = fcnt_q[i];
            if (!attack[i] || stunned[i]) begin
                phase_d[i] = PH_IDLE;
                fcnt_d[i]  = '0;
            end else begin
                case (phase_q[i])
                    PH_IDLE: begin
                        // Only a fresh ATTACK edge arms; a held ATTACK stays put.
                        if (!prev_att_q[i]) begin
                            phase_d[i] = (SU_N == '0) ? PH_ACTIVE : PH_STARTUP;
                            fcnt_d[i]  = '0;
                        end
                    end
                    PH_STARTUP: begin
                        if (frame_tick) begin
                            if (fcnt_q[i] + CW'(1) >= SU_N) begin
                                phase_d[i] = PH_ACTIVE;
                                fcnt_d[i]  = '0;
                            end else begin
                                fcnt_d[i] = fcnt_q[i] + CW'(1);
                            end
                        end
                    end
                    PH_ACTIVE: begin
                        if (hit_q[i]) begin
                            phase_d[i] = PH_SPENT;
                        end else if (frame_tick) begin
                            if (fcnt_q[i] + CW'(1) >= AC_N) begin
                                phase_d[i] = PH_SPENT;
                                fcnt_d[i]  = '0;
                            end else begin
                                fcnt_d[i] = fcnt_q[i] + CW'(1);
                            end
                        end
                    end
                    PH_SPENT: phase_d[i] = PH_SPENT;
                    default:  phase_d[i] = PH_IDLE;
                endcase
            end
        end
    end

    // A landing hit reloads the victim's stun and wins over the frame decrement.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            stun_d[i] = stun_q[i];
            if (hit_d[1-i]) begin
                stun_d[i] = HS_N;
            end else if (frame_tick && (stun_q[i] != '0)) begin
                stun_d[i] = stun_q[i] - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_q      <= '0;
            prev_att_q <= '0;
            for (int i = 0; i < 2; i++) begin
                phase_q[i] <= PH_IDLE;
                fcnt_q[i]  <= '0;
                stun_q[i]  <= '0;
            end
        end else begin
            hit_q      <= hit_d;
            prev_att_q <= attack;
            for (int i = 0; i < 2; i++) begin
                phase_q[i] <= phase_d[i];
                fcnt_q[i]  <= fcnt_d[i];
                stun_q[i]  <= stun_d[i];
            end
        end
    end

    assign hit1_lands   = hit_q[0];
    assign hit2_lands   = hit_q[1];
    assign trade        = hit_q[0] & hit_q[1];
    assign p1_stunned   = (stun_q[0] != '0);
    assign p2_stunned   = (stun_q[1] != '0);
    assign p1_phase_dbg = phase_q[0];
    assign p2_phase_dbg = phase_q[1];

endmodule

// File: tb/tb_hit_resolver.sv
// Directed bench for hit_resolver: hand-computed scenarios for hits, edge touch,
// trades, left-edge clamping, one-hit latch, stun reload and mid-attack reset.
module tb_hit_resolver;

    localparam logic [2:0] ATK = 3'b010;
    localparam logic [2:0] IDL = 3'b000;
    localparam logic [1:0] PH_IDLE    = 2'd0;
    localparam logic [1:0] PH_STARTUP = 2'd1;
    localparam logic [1:0] PH_ACTIVE  = 2'd2;
    localparam logic [1:0] PH_SPENT   = 2'd3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame_tick = 1'b0;
    logic [9:0] char1_x = '0, char1_y = '0, char2_x = '0, char2_y = '0;
    logic [2:0] char1_state = IDL, char2_state = IDL;
    logic       char1_facing_right = 1'b1, char2_facing_right = 1'b1;
    logic       hit1_lands, hit2_lands, trade, p1_stunned, p2_stunned;
    logic [1:0] p1_phase_dbg, p2_phase_dbg;

    int total = 0;
    int bad = 0;
    int n_hit1 = 0;
    int n_hit2 = 0;
    int n_trade = 0;

    hit_resolver dut (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick),
        .char1_x(char1_x), .char1_y(char1_y), .char2_x(char2_x), .char2_y(char2_y),
        .char1_state(char1_state), .char2_state(char2_state),
        .char1_facing_right(char1_facing_right), .char2_facing_right(char2_facing_right),
        .hit1_lands(hit1_lands), .hit2_lands(hit2_lands), .trade(trade),
        .p1_stunned(p1_stunned), .p2_stunned(p2_stunned),
        .p1_phase_dbg(p1_phase_dbg), .p2_phase_dbg(p2_phase_dbg)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (hit1_lands) n_hit1++;
        if (hit2_lands) n_hit2++;
        if (trade) n_trade++;
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        step();
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic place(input logic [9:0] x1, input logic [9:0] y1, input logic f1,
                         input logic [9:0] x2, input logic [9:0] y2, input logic f2);
        char1_x = x1; char1_y = y1; char1_facing_right = f1;
        char2_x = x2; char2_y = y2; char2_facing_right = f2;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        char1_state = IDL;
        char2_state = IDL;
        frame_tick = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        n_hit1 = 0;
        n_hit2 = 0;
        n_trade = 0;
    endtask

    initial begin
        do_reset();
        check_eq("reset_outs", {27'd0, hit1_lands, hit2_lands, trade, p1_stunned, p2_stunned}, 32'd0);
        check_eq("reset_phases", {28'd0, p1_phase_dbg, p2_phase_dbg}, 32'd0);

        // P1 hitbox [164,184) reaches into P2 body [170,234).
        place(10'd100, 10'd200, 1'b1, 10'd170, 10'd200, 1'b1);
        char1_state = ATK;
        step();
        check_eq("basic_startup", p1_phase_dbg, PH_STARTUP);
        ticks(2);
        check_eq("basic_no_early_hit", n_hit1, 0);
        tick();
        check_eq("basic_hit", hit1_lands, 1);
        check_eq("basic_stun_set", p2_stunned, 1);
        step();
        check_eq("basic_pulse_end", hit1_lands, 0);
        check_eq("basic_spent", p1_phase_dbg, PH_SPENT);
        ticks(11);
        check_eq("basic_stun_11", p2_stunned, 1);
        tick();
        check_eq("basic_stun_12", p2_stunned, 0);
        check_eq("basic_one_pulse", n_hit1, 1);
        do_reset();

        // Hitbox right edge at 184 only touches P2 body at 184.
        place(10'd100, 10'd200, 1'b1, 10'd184, 10'd200, 1'b1);
        char1_state = ATK;
        step();
        ticks(3);
        check_eq("touch_active", p1_phase_dbg, PH_ACTIVE);
        ticks(2);
        check_eq("touch_spent", p1_phase_dbg, PH_SPENT);
        check_eq("touch_no_hit", n_hit1, 0);
        check_eq("touch_no_stun", p2_stunned, 0);
        do_reset();

        // Facing each other: P1 box [164,184) vs P2 [130,194); P2 box [110,130) vs P1 [100,164).
        place(10'd100, 10'd200, 1'b1, 10'd130, 10'd200, 1'b0);
        char1_state = ATK;
        char2_state = ATK;
        step();
        ticks(3);
        check_eq("trade_flags", {29'd0, hit1_lands, hit2_lands, trade}, 32'd7);
        check_eq("trade_stuns", {30'd0, p1_stunned, p2_stunned}, 32'd3);
        step();
        check_eq("trade_pulse_once", n_trade, 1);
        check_eq("trade_forced_idle", {28'd0, p1_phase_dbg, p2_phase_dbg}, 32'd0);
        do_reset();

        // P2 at x=10 facing left: box clamps to [0,20), striking P1 at x=0.
        place(10'd0, 10'd200, 1'b1, 10'd10, 10'd200, 1'b0);
        char2_state = ATK;
        step();
        ticks(3);
        check_eq("clamp_hit", hit2_lands, 1);
        check_eq("clamp_stun", p1_stunned, 1);
        check_eq("clamp_p1_no_hit", n_hit1, 0);
        do_reset();

        // Same clamp with P1 far right: a wrapped box near x=1014 would wrongly hit.
        place(10'd990, 10'd200, 1'b0, 10'd10, 10'd200, 1'b0);
        char2_state = ATK;
        step();
        ticks(5);
        check_eq("nowrap_no_hit", n_hit2, 0);
        check_eq("nowrap_no_stun", p1_stunned, 0);
        check_eq("nowrap_spent", p2_phase_dbg, PH_SPENT);
        do_reset();

        // Held ATTACK gives one hit; re-presses hit again and reload stun.
        place(10'd100, 10'd200, 1'b1, 10'd170, 10'd200, 1'b1);
        char1_state = ATK;
        step();
        ticks(40);
        check_eq("held_one_pulse", n_hit1, 1);
        check_eq("held_stun_over", p2_stunned, 0);
        check_eq("held_spent", p1_phase_dbg, PH_SPENT);
        char1_state = IDL;
        step();
        check_eq("drop_idle", p1_phase_dbg, PH_IDLE);
        char1_state = ATK;
        step();
        ticks(3);
        check_eq("repress_pulse", n_hit1, 2);
        check_eq("repress_stun", p2_stunned, 1);
        char1_state = IDL;
        step();
        char1_state = ATK;
        step();
        ticks(3);
        check_eq("reload_pulse", n_hit1, 3);
        ticks(11);
        check_eq("reload_stun_11", p2_stunned, 1);
        tick();
        check_eq("reload_stun_12", p2_stunned, 0);
        do_reset();

        // Reset mid-ACTIVE and mid-stun, then restart with ATTACK still held.
        place(10'd100, 10'd200, 1'b1, 10'd170, 10'd200, 1'b1);
        char1_state = ATK;
        step();
        ticks(3);
        check_eq("rst_pre_hit", {29'd0, hit1_lands, p2_stunned, p1_phase_dbg == PH_ACTIVE}, 32'd7);
        rst_n = 1'b0;
        #1;
        check_eq("rst_async_outs", {27'd0, hit1_lands, hit2_lands, trade, p1_stunned, p2_stunned}, 32'd0);
        check_eq("rst_async_phase", p1_phase_dbg, PH_IDLE);
        step();
        step();
        rst_n = 1'b1;
        n_hit1 = 0;
        step();
        check_eq("rst_new_startup", p1_phase_dbg, PH_STARTUP);
        ticks(2);
        check_eq("rst_no_early_hit", n_hit1, 0);
        tick();
        check_eq("rst_rehit", hit1_lands, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
